// File: rtl/mem_stage_dmem.sv
// MEM stage of the 5-stage pipeline: word-addressed data memory with fixed wait states and a stall to the hazard unit.
// Optional feature: define MEM_STAGE_MISALIGN_TRAP_EN to add misalign_out and suppress misaligned accesses.
module mem_stage_dmem #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [31:0] address_in,
  input  logic [31:0] write_data_in,
  output logic [31:0] read_data_out,
  output logic        stall_out,
  output logic        done_out
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  , output logic      misalign_out
`endif
);

  localparam int         AW     = $clog2(DEPTH);
  localparam logic [3:0] WAIT_C = 4'(WAIT_CYCLES);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] mem_q [DEPTH];
  logic [AW-1:0] idx_s;
  logic        req_s;
  logic        misalign_s;
  logic        we_s;
  logic        stall_s;
  logic        done_s;
  logic [31:0] rdata_s;
  logic        unused_s;

  assign idx_s    = address_in[AW+1:2];
  assign req_s    = mem_read_in | mem_write_in;
  assign unused_s = ^{address_in[31:AW+2], address_in[1:0]};

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  assign misalign_s   = (address_in[1:0] != 2'b00);
  assign misalign_out = done_s & misalign_s;
`else
  assign misalign_s = 1'b0;
`endif

  // Next-state, wait counter and access outputs; reset forces everything quiet.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_s = 1'b0;
    done_s  = 1'b0;
    rdata_s = 32'h0000_0000;
    we_s    = 1'b0;
    if (rst) begin
      state_d = S_IDLE;
      cnt_d   = 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!req_s) begin
            cnt_d = 4'd0;
          end else if (WAIT_C == 4'd0) begin
            done_s = 1'b1;
          end else begin
            stall_s = 1'b1;
            cnt_d   = 4'd1;
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (!req_s) begin
            // Request withdrawn while waiting: abandon without committing.
            state_d = S_IDLE;
            cnt_d   = 4'd0;
          end else if (cnt_q >= WAIT_C) begin
            done_s  = 1'b1;
            state_d = S_IDLE;
            cnt_d   = 4'd0;
          end else begin
            stall_s = 1'b1;
            cnt_d   = cnt_q + 4'd1;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end
      endcase
      // Completion: a store wins over a simultaneous load.
      if (done_s && !misalign_s) begin
        if (mem_write_in) begin
          we_s = 1'b1;
        end else begin
          rdata_s = mem_q[idx_s];
        end
      end else begin
        we_s = 1'b0;
      end
    end
  end

  assign read_data_out = rdata_s;
  assign stall_out     = stall_s;
  assign done_out      = done_s;

  // State and wait-counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Data memory array, cleared on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'h0000_0000;
      end
    end else if (we_s) begin
      mem_q[idx_s] <= write_data_in;
    end
  end

endmodule

// File: doc/mem_stage_dmem.md
Name: mem_stage_dmem

Overview:
- Memory-access stage of the 5-stage MIPS pipeline. Sits directly downstream of the EX/MEM pipeline register and consumes its address, write-data and mem_read/mem_write outputs.
- Contains the word-addressed data memory. A fixed number of wait states is inserted per access, and the block raises a stall to the hazard unit until the access completes.
- Read data feeds the MEM/WB register.

Parameters:
- DEPTH, 256, number of 32-bit words in data memory; power of two.
- WAIT_CYCLES, 2, stall cycles inserted per access (0..15); 0 = single-cycle access.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- mem_read_in  input  1  load request from EX/MEM
- mem_write_in  input  1  store request from EX/MEM
- address_in  input  32  byte address (ALU result) from EX/MEM
- write_data_in  input  32  store data from EX/MEM
- read_data_out  output  32  load data to MEM/WB; valid only in the completion cycle
- stall_out  output  1  high while the access is incomplete; hazard unit freezes PC, IF/ID, ID/EX and EX/MEM, and bubbles MEM/WB
- done_out  output  1  one-cycle pulse in the access completion cycle

Behaviour:
- Word index = address_in[log2(DEPTH)+1:2]. Upper bits are ignored, so addresses wrap modulo DEPTH*4.
- Request is defined as req = mem_read_in | mem_write_in.
- Both read and write asserted: treated as a write; read_data_out = 0.
- Reset:
  - State goes to IDLE and the counter to 0.
  - All memory words are cleared to 0.
  - read_data_out = 0, stall_out = 0, done_out = 0.
- FSM states are IDLE and WAIT. Counter cnt is 4 bits.
- IDLE, req = 0: all outputs 0.
- IDLE, req = 1, WAIT_CYCLES = 0: the access completes in the same cycle.
  - stall_out = 0, done_out = 1.
  - Read data comes from the combinational array read.
  - A write commits at the closing posedge.
- IDLE, req = 1, WAIT_CYCLES > 0: stall_out = 1 (combinational); at posedge cnt <= 1 and state <= WAIT.
- WAIT, cnt < WAIT_CYCLES: stall_out = 1; cnt increments at posedge.
- WAIT, cnt == WAIT_CYCLES (completion cycle):
  - stall_out = 0, done_out = 1.
  - For a read, read_data_out = mem[index].
  - For a write, mem[index] <= write_data_in at posedge.
  - State <= IDLE.
- Latency:
  - Each access occupies WAIT_CYCLES+1 cycles.
  - stall_out is high for exactly WAIT_CYCLES consecutive cycles, starting combinationally in the request cycle.
  - A back-to-back request is accepted in the cycle after completion.
- Inputs are held stable by the upstream freeze during WAIT. If req drops during WAIT, the access is abandoned: state <= IDLE, no write, done_out stays 0.
- read_data_out = 0 in every cycle except a read completion cycle.
- rst asserted mid-access: immediate return to IDLE and the pending write is not committed.

Optional Feature:
- Macro: MEM_STAGE_MISALIGN_TRAP_EN
- Defined:
  - Adds output misalign_out (1 bit), pulsed in the completion cycle when req = 1 and address_in[1:0] != 0.
  - A misaligned store is suppressed (memory unchanged); a misaligned load returns read_data_out = 0.
  - Timing and stall are unchanged.
  - misalign_out resets to 0.
- Not defined: port absent; address_in[1:0] ignored.

Test Plan:
- WAIT_CYCLES=2, write 0xDEADBEEF to 0x10, then read 0x10 -> stall_out high 2 cycles per access, done_out pulses on the 3rd cycle, read_data_out = 0xDEADBEEF in the read completion cycle and 0 otherwise.
- WAIT_CYCLES=0, back-to-back writes to 0x0, 0x4, then reads -> stall_out never asserted, data 1-cycle accessible, done_out high every request cycle.
- Read and write both high, address 0x8, data 0x12345678 -> treated as write, read_data_out = 0, subsequent read of 0x8 = 0x12345678.
- DEPTH=256, write 0xA5A5A5A5 to 0x400 -> read of 0x000 returns 0xA5A5A5A5 (wrap).
- Assert rst during WAIT of a write to 0x20 -> outputs 0 immediately, subsequent read of 0x20 returns 0.
- With MEM_STAGE_MISALIGN_TRAP_EN, write 0x11111111 to 0x22 -> misalign_out pulses in the completion cycle, read of 0x20 returns 0.
